dcache_refill_engine: RTL and testbench

DCACHE_REFILL_ENGINE -- requirements
Module: dcache_refill_engine

---
 rtl/dcache_refill_engine_pkg.sv | 46 ++++
 rtl/dcache_line_parity.sv | 16 +
 rtl/dcache_refill_engine.sv | 147 ++++++++++++++
 tb/tb_dcache_refill_engine.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_refill_engine_pkg.sv
// Shared D$ refill types: memory op codes, refill FSM states, wide cache-RAM write record.
package dcache_refill_engine_pkg;

    localparam int NTHREADIDMSB = 3;
    localparam int DRAM_BEAT_W  = 128;
    localparam int LINE_W       = 2 * DRAM_BEAT_W;

    typedef enum logic [1:0] {
        DCACHE_LD  = 2'd0,
        DCACHE_WB  = 2'd1,
        DMMU_WALK  = 2'd2,
        DTLB_WRITE = 2'd3
    } dmem_op_type;

    typedef enum logic [2:0] {
        IDLE, CMD, WBEAT0, WBEAT1, RBEAT0, RBEAT1, FILL, DONE
    } refill_state_t;

    typedef struct packed {
        logic [23:0] tag;
        logic        valid;
        logic        dirty;
        logic        parity;
    } cache_tag_type;

    typedef struct packed {
        logic [31:0] D;
    } cache_ecc_type;

    typedef struct packed {
        logic [NTHREADIDMSB:0] tid;
        logic [2:0]            index;
        cache_tag_type         tag;
        logic                  we_tag;
        logic [3:0]            we_data;
        logic [LINE_W-1:0]     data;
        cache_ecc_type         ecc_parity;
        logic                  ecc_error;
    } cache_ram_write_wide_in_type;

    // Only line loads and writebacks touch DRAM; everything else is rejected.
    function automatic logic is_mem_op(input dmem_op_type op);
        return (op == DCACHE_LD) || (op == DCACHE_WB);
    endfunction

endpackage

// File: rtl/dcache_line_parity.sv
// Even parity per byte of a 256-bit cache line (bit i covers byte i).
module dcache_line_parity
    import dcache_refill_engine_pkg::*;
(
    input  logic [LINE_W-1:0] line,
    output logic [31:0]       parity
);

    always_comb begin
        parity = '0;
        for (int i = 0; i < 32; i++) begin
            parity[i] = ^line[i*8 +: 8];
        end
    end

endmodule

// File: rtl/dcache_refill_engine.sv
// D$ line refill / writeback engine: one request at a time, two 128-bit DRAM beats per line.
// Define DCACHE_REFILL_PARITY_EN to emit byte and tag parity with the FILL write.
module dcache_refill_engine
    import dcache_refill_engine_pkg::*;
(
    input  logic                        gclk,
    input  logic                        rstn,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  dmem_op_type                 req_op,
    input  logic [NTHREADIDMSB:0]       req_tid,
    input  logic [26:0]                 req_addr,
    input  logic [LINE_W-1:0]           req_wbdata,
    output logic                        mem_cmd_valid,
    input  logic                        mem_cmd_ready,
    output logic                        mem_cmd_we,
    output logic [26:0]                 mem_cmd_addr,
    output logic [DRAM_BEAT_W-1:0]      mem_wdata,
    output logic                        mem_wdata_valid,
    input  logic                        mem_wdata_ready,
    input  logic [DRAM_BEAT_W-1:0]      mem_rdata,
    input  logic                        mem_rdata_valid,
    output cache_ram_write_wide_in_type cram_out,
    output logic                        cram_we,
    output logic                        done_valid,
    output logic [NTHREADIDMSB:0]       done_tid,
    output logic                        done_err
);

`ifdef DCACHE_REFILL_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    refill_state_t         state, state_nxt;
    dmem_op_type           op_q;
    logic [NTHREADIDMSB:0] tid_q;
    logic [26:0]           addr_q;
    logic [LINE_W-1:0]     wbdata_q;
    logic [LINE_W-1:0]     line_q;
    logic [31:0]           line_par;
    logic                  req_fire;

    assign req_fire = req_valid && rstn && (state == IDLE);

    dcache_line_parity u_line_parity (
        .line   (line_q),
        .parity (line_par)
    );

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Request and line buffers carry no reset; they are only read in states entered after a capture.
    always_ff @(posedge gclk) begin
        if (req_fire) begin
            op_q     <= req_op;
            tid_q    <= req_tid;
            addr_q   <= req_addr;
            wbdata_q <= req_wbdata;
        end
        if (state == RBEAT0 && mem_rdata_valid) begin
            line_q[DRAM_BEAT_W-1:0] <= mem_rdata;
        end
        if (state == RBEAT1 && mem_rdata_valid) begin
            line_q[LINE_W-1:DRAM_BEAT_W] <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt       = state;
        req_ready       = 1'b0;
        mem_cmd_valid   = 1'b0;
        mem_cmd_we      = 1'b0;
        mem_cmd_addr    = '0;
        mem_wdata       = '0;
        mem_wdata_valid = 1'b0;
        cram_we         = 1'b0;
        cram_out        = '0;
        done_valid      = 1'b0;
        done_tid        = '0;
        done_err        = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = rstn;
                if (req_fire) begin
                    if (is_mem_op(req_op)) state_nxt = CMD;
                    else                   state_nxt = DONE;
                end
            end
            CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_we    = (op_q == DCACHE_WB);
                mem_cmd_addr  = addr_q;
                if (mem_cmd_ready) begin
                    if (op_q == DCACHE_WB) state_nxt = WBEAT0;
                    else                   state_nxt = RBEAT0;
                end
            end
            WBEAT0: begin
                mem_wdata_valid = 1'b1;
                mem_wdata       = wbdata_q[DRAM_BEAT_W-1:0];
                if (mem_wdata_ready) state_nxt = WBEAT1;
            end
            WBEAT1: begin
                mem_wdata_valid = 1'b1;
                mem_wdata       = wbdata_q[LINE_W-1:DRAM_BEAT_W];
                if (mem_wdata_ready) state_nxt = DONE;
            end
            RBEAT0: begin
                if (mem_rdata_valid) state_nxt = RBEAT1;
            end
            RBEAT1: begin
                if (mem_rdata_valid) state_nxt = FILL;
            end
            FILL: begin
                cram_we                 = 1'b1;
                cram_out.tid            = tid_q;
                cram_out.index          = addr_q[2:0];
                cram_out.tag.tag        = addr_q[26:3];
                cram_out.tag.valid      = 1'b1;
                cram_out.tag.dirty      = 1'b0;
                cram_out.tag.parity     = PARITY_EN & (^addr_q[26:3]);
                cram_out.we_tag         = 1'b1;
                cram_out.we_data        = 4'b1111;
                cram_out.data           = line_q;
                cram_out.ecc_parity.D   = PARITY_EN ? line_par : 32'd0;
                cram_out.ecc_error      = 1'b0;
                state_nxt               = DONE;
            end
            DONE: begin
                done_valid = 1'b1;
                done_tid   = tid_q;
                done_err   = !is_mem_op(op_q);
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dcache_refill_engine.sv
// Randomized self-checking bench for dcache_refill_engine against a transaction-level model.
module tb_dcache_refill_engine;
    import dcache_refill_engine_pkg::*;

    typedef logic [335:0] cv_t;

    logic                        gclk = 1'b0;
    logic                        rstn = 1'b0;
    logic                        req_valid = 1'b0;
    logic                        req_ready;
    dmem_op_type                 req_op = DCACHE_LD;
    logic [3:0]                  req_tid = '0;
    logic [26:0]                 req_addr = '0;
    logic [255:0]                req_wbdata = '0;
    logic                        mem_cmd_valid;
    logic                        mem_cmd_ready = 1'b0;
    logic                        mem_cmd_we;
    logic [26:0]                 mem_cmd_addr;
    logic [127:0]                mem_wdata;
    logic                        mem_wdata_valid;
    logic                        mem_wdata_ready = 1'b0;
    logic [127:0]                mem_rdata = '0;
    logic                        mem_rdata_valid = 1'b0;
    cache_ram_write_wide_in_type cram_out;
    logic                        cram_we;
    logic                        done_valid;
    logic [3:0]                  done_tid;
    logic                        done_err;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_cram = 0, n_cmd = 0, n_wv = 0, n_done = 0, cram_cyc = 0;
    cache_ram_write_wide_in_type last_cram;

    dcache_refill_engine dut (
        .gclk            (gclk),
        .rstn            (rstn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_op          (req_op),
        .req_tid         (req_tid),
        .req_addr        (req_addr),
        .req_wbdata      (req_wbdata),
        .mem_cmd_valid   (mem_cmd_valid),
        .mem_cmd_ready   (mem_cmd_ready),
        .mem_cmd_we      (mem_cmd_we),
        .mem_cmd_addr    (mem_cmd_addr),
        .mem_wdata       (mem_wdata),
        .mem_wdata_valid (mem_wdata_valid),
        .mem_wdata_ready (mem_wdata_ready),
        .mem_rdata       (mem_rdata),
        .mem_rdata_valid (mem_rdata_valid),
        .cram_out        (cram_out),
        .cram_we         (cram_we),
        .done_valid      (done_valid),
        .done_tid        (done_tid),
        .done_err        (done_err)
    );

    always #5 gclk = ~gclk;

    task automatic check(input string tag, input cv_t act, input cv_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Reference: byte i parity bit is 1 when byte i holds an odd number of ones.
    function automatic logic [31:0] model_line_par(input logic [255:0] line);
        logic [31:0] p = '0;
`ifdef DCACHE_REFILL_PARITY_EN
        for (int b = 0; b < 32; b++) begin
            int ones = 0;
            for (int k = 0; k < 8; k++) ones += int'(line[b*8+k]);
            p[b] = (ones % 2) == 1;
        end
`endif
        return p;
    endfunction

    function automatic logic model_tag_par(input logic [23:0] tag);
        logic p = 1'b0;
`ifdef DCACHE_REFILL_PARITY_EN
        int ones = 0;
        for (int k = 0; k < 24; k++) ones += int'(tag[k]);
        p = (ones % 2) == 1;
`endif
        return p;
    endfunction

    // Advance one clock and sample outputs 1 time unit after the rising edge.
    task automatic step();
        @(posedge gclk);
        #1;
        cyc++;
        if (cram_we) begin
            n_cram++;
            last_cram = cram_out;
            cram_cyc  = cyc;
        end
        if (mem_cmd_valid)   n_cmd++;
        if (mem_wdata_valid) n_wv++;
        if (done_valid)      n_done++;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, cv_t'(req_ready), cv_t'(0));
        check({tag, "_cmd"}, cv_t'({mem_cmd_valid, mem_cmd_we, mem_cmd_addr}), cv_t'(0));
        check({tag, "_wdata"}, cv_t'({mem_wdata_valid, mem_wdata}), cv_t'(0));
        check({tag, "_cram"}, cv_t'({cram_we, cram_out}), cv_t'(0));
        check({tag, "_done"}, cv_t'({done_valid, done_tid, done_err}), cv_t'(0));
    endtask

    task automatic run_txn(input dmem_op_type op, input logic [26:0] addr, input logic [3:0] tid,
                           input logic [255:0] wb, input logic [127:0] ra, input logic [127:0] rb,
                           input int cmd_stall, input int wstall, input int rgap_max,
                           input bit stray, input bit chk_lat);
        bit is_mem = (op == DCACHE_LD) || (op == DCACHE_WB);
        bit is_ld  = (op == DCACHE_LD);
        bit is_wb  = (op == DCACHE_WB);
        bit cmd_acc = 1'b0;
        bit fin = 1'b0;
        int c0, cram0, cmd0, wv0, stall_left, wleft, bw, rbi, gap, last_wacc;
        logic [3:0] got_tid = '0;
        logic got_err = 1'b0;
        if (stray) begin
            mem_rdata_valid = 1'b1;
            mem_rdata = rnd128();
            step();
            mem_rdata_valid = 1'b0;
        end
        check("req_ready_idle", cv_t'(req_ready), cv_t'(1));
        req_valid = 1'b1; req_op = op; req_addr = addr; req_tid = tid; req_wbdata = wb;
        c0 = cyc; cram0 = n_cram; cmd0 = n_cmd; wv0 = n_wv;
        stall_left = cmd_stall; wleft = wstall; bw = 0; rbi = 0; last_wacc = -100;
        gap = (rgap_max > 0) ? int'($urandom_range(0, rgap_max)) : 0;
        for (int k = 0; k < 300 && !fin; k++) begin
            step();
            req_valid = 1'b0;
            req_wbdata = {rnd128(), rnd128()};
            mem_cmd_ready = 1'b0;
            mem_wdata_ready = 1'b0;
            mem_rdata_valid = 1'b0;
            mem_rdata = rnd128();
            if (done_valid) begin
                fin = 1'b1;
                got_tid = done_tid;
                got_err = done_err;
            end else if (mem_cmd_valid) begin
                check("cmd_addr", cv_t'(mem_cmd_addr), cv_t'(addr));
                check("cmd_we", cv_t'(mem_cmd_we), cv_t'(is_wb));
                if (stall_left > 0) begin
                    stall_left--;
                    mem_rdata_valid = stray;
                end else begin
                    mem_cmd_ready = 1'b1;
                    cmd_acc = 1'b1;
                end
            end else if (mem_wdata_valid) begin
                check("wdata_beat", cv_t'(mem_wdata), cv_t'(bw == 0 ? wb[127:0] : wb[255:128]));
                if (wleft > 0) begin
                    wleft--;
                end else begin
                    mem_wdata_ready = 1'b1;
                    bw++;
                    wleft = wstall;
                    last_wacc = cyc;
                end
            end else if (cmd_acc && is_ld && rbi < 2) begin
                if (gap > 0) begin
                    gap--;
                end else begin
                    mem_rdata_valid = 1'b1;
                    mem_rdata = (rbi == 0) ? ra : rb;
                    rbi++;
                    gap = (rgap_max > 0) ? int'($urandom_range(0, rgap_max)) : 0;
                end
            end
        end
        check("done_seen", cv_t'(fin), cv_t'(1));
        check("done_tid", cv_t'(got_tid), cv_t'(tid));
        check("done_err", cv_t'(got_err), cv_t'(!is_mem));
        check("cram_count", cv_t'(n_cram - cram0), cv_t'(is_ld ? 1 : 0));
        check("cmd_cycles", cv_t'(n_cmd - cmd0), cv_t'(is_mem ? cmd_stall + 1 : 0));
        check("wbeat_cycles", cv_t'(n_wv - wv0), cv_t'(is_wb ? 2 * (wstall + 1) : 0));
        if (is_ld && (n_cram - cram0) == 1) begin
            check("fill_data", cv_t'(last_cram.data), cv_t'({rb, ra}));
            check("fill_index", cv_t'(last_cram.index), cv_t'(addr[2:0]));
            check("fill_tag", cv_t'(last_cram.tag.tag), cv_t'(addr[26:3]));
            check("fill_ctrl", cv_t'({last_cram.tid, last_cram.tag.valid, last_cram.tag.dirty,
                                      last_cram.we_tag, last_cram.we_data, last_cram.ecc_error}),
                  cv_t'({tid, 1'b1, 1'b0, 1'b1, 4'b1111, 1'b0}));
            check("fill_parity", cv_t'(last_cram.ecc_parity.D), cv_t'(model_line_par({rb, ra})));
            check("fill_tag_par", cv_t'(last_cram.tag.parity), cv_t'(model_tag_par(addr[26:3])));
        end
        if (is_wb) begin
            check("wb_beats", cv_t'(bw), cv_t'(2));
            check("wb_done_lat", cv_t'(cyc - last_wacc), cv_t'(1));
        end
        if (chk_lat) begin
            if (is_ld) begin
                check("ld_fill_cycle", cv_t'(cram_cyc - c0), cv_t'(4));
                check("ld_done_cycle", cv_t'(cyc - c0), cv_t'(5));
            end else if (!is_mem) begin
                check("bad_done_cycle", cv_t'(cyc - c0), cv_t'(1));
            end
        end
        step();
        check("done_pulse_end", cv_t'({done_valid, req_ready}), cv_t'(2'b01));
    endtask

    initial begin
        logic [127:0] a, b, h, l;
        logic [127:0] ones01;
        int cram0, done0;

        // Reset state
        step();
        check_all_zero("rst_hold");
        step();
        rstn = 1'b1;
        step();
        check("rst_release_ready", cv_t'(req_ready), cv_t'(1));

        // Directed load, back-to-back beats, exact latency
        a = rnd128(); b = rnd128();
        run_txn(DCACHE_LD, 27'h0000123, 4'd5, '0, a, b, 0, 0, 0, 1'b0, 1'b1);
        check("ld123_index", cv_t'(last_cram.index), cv_t'(3));

        // Writeback with 3 stall cycles per beat
        h = rnd128(); l = rnd128();
        run_txn(DCACHE_WB, 27'h0000040, 4'd2, {h, l}, '0, '0, 0, 3, 0, 1'b0, 1'b0);

        // Rejected ops
        run_txn(DTLB_WRITE, 27'h1abcdef, 4'd9, '0, '0, '0, 0, 0, 0, 1'b0, 1'b1);
        run_txn(DMMU_WALK, 27'h0000777, 4'd14, '0, '0, '0, 0, 0, 0, 1'b0, 1'b1);

        // Stray read beats in IDLE and CMD
        a = rnd128(); b = rnd128();
        run_txn(DCACHE_LD, 27'h2345678, 4'd7, '0, a, b, 2, 0, 1, 1'b1, 1'b0);

        // Parity corner: every byte 8'h01
        ones01 = {16{8'h01}};
        run_txn(DCACHE_LD, 27'h0000008, 4'd1, '0, ones01, ones01, 0, 0, 0, 1'b0, 1'b1);
`ifdef DCACHE_REFILL_PARITY_EN
        check("par_all01", cv_t'(last_cram.ecc_parity.D), cv_t'(32'hFFFFFFFF));
`else
        check("par_all01", cv_t'(last_cram.ecc_parity.D), cv_t'(32'h0));
`endif

        // Reset asserted while waiting for the second read beat
        cram0 = n_cram; done0 = n_done;
        req_valid = 1'b1; req_op = DCACHE_LD; req_addr = 27'h0000321; req_tid = 4'd3;
        step();
        req_valid = 1'b0; mem_cmd_ready = 1'b1;
        step();
        mem_cmd_ready = 1'b0; mem_rdata_valid = 1'b1; mem_rdata = rnd128();
        step();
        mem_rdata_valid = 1'b0;
        rstn = 1'b0;
        #1;
        check_all_zero("rst_mid");
        step();
        check_all_zero("rst_mid_hold");
        rstn = 1'b1;
        step();
        check("rst_mid_ready", cv_t'(req_ready), cv_t'(1));
        check("rst_mid_no_fill", cv_t'(n_cram - cram0), cv_t'(0));
        check("rst_mid_no_done", cv_t'(n_done - done0), cv_t'(0));
        a = rnd128(); b = rnd128();
        run_txn(DCACHE_LD, 27'h0000321, 4'd3, '0, a, b, 0, 0, 0, 1'b0, 1'b1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            dmem_op_type op;
            int sel;
            sel = int'($urandom_range(0, 9));
            op = (sel < 5) ? DCACHE_LD : (sel < 8) ? DCACHE_WB : (sel == 8) ? DMMU_WALK : DTLB_WRITE;
            run_txn(op, 27'($urandom()), 4'($urandom()), {rnd128(), rnd128()}, rnd128(), rnd128(),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
